// File: rtl/nibble_serial_adder_ctrl.sv
// Serial wide adder: feeds one nibble per cycle through an external 4-bit adder, LSB first.
// Latency NIBBLES+1 edges from Start to Done; Start is ignored while RUN, accepted in IDLE/DONE.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   CLK,
   input  logic                   CLR_n,
   input  logic                   Start,
   input  logic [4*NIBBLES-1:0]   OpA,
   input  logic [4*NIBBLES-1:0]   OpB,
   input  logic                   CinIn,
   output logic                   Busy,
   output logic                   Done,
   output logic [4*NIBBLES-1:0]   Result,
   output logic                   CoutOut,
   output logic [3:0]             AddA,
   output logic [3:0]             AddB,
   output logic                   AddCin,
   input  logic [3:0]             AddSum,
   input  logic                   AddCout
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES + 1);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    a_lat, b_lat, sum_q;
   logic [IW-1:0]   idx;
   logic            carry, cout_q;
   logic            accept, last;

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = (idx == LAST);
      Busy      = 1'b0;
      Done      = 1'b0;
      AddA      = 4'h0;
      AddB      = 4'h0;
      AddCin    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            Busy   = 1'b1;
            AddA   = a_lat[{idx, 2'b00} +: 4];
            AddB   = b_lat[{idx, 2'b00} +: 4];
            AddCin = carry;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            Busy = 1'b1;
            Done = 1'b1;
            // Back-to-back: a Start seen here starts the next addition immediately.
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         a_lat  <= '0;
         b_lat  <= '0;
         sum_q  <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
      end else if (accept) begin
         a_lat  <= OpA;
         b_lat  <= OpB;
         carry  <= CinIn;
         idx    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (state == RUN) begin
         sum_q[{idx, 2'b00} +: 4] <= AddSum;
         carry                    <= AddCout;
         // Index parks on the last nibble rather than wrapping.
         if (last) cout_q <= AddCout;
         else      idx    <= idx + IW'(1);
      end
   end

   assign Result  = sum_q;
   assign CoutOut = cout_q;

endmodule
